// File: rtl/vshadow_ctrl_if.sv
// CPU strobe/data bus and vertical-timebase outputs of the shadow-register controller.
// master drives writes and timing pulses; slave is the controller.
interface vshadow_ctrl_if;
  logic [7:0] WD;
  logic       STARTL, STARTH, ENDL, ENDH, INTL, INTH;
  logic       VCNTL, VCNTH;
  logic       NEXTV, HD1, DIAG;
  logic [8:0] ACT_START, ACT_END, ACT_INT;
  logic       VLDL;
  logic [8:0] VLDD;
  logic       COMMIT, PENDING;

  modport master (
    output WD, STARTL, STARTH, ENDL, ENDH, INTL, INTH, VCNTL, VCNTH, NEXTV, HD1, DIAG,
    input  ACT_START, ACT_END, ACT_INT, VLDL, VLDD, COMMIT, PENDING
  );

  modport slave (
    input  WD, STARTL, STARTH, ENDL, ENDH, INTL, INTH, VCNTL, VCNTH, NEXTV, HD1, DIAG,
    output ACT_START, ACT_END, ACT_INT, VLDL, VLDD, COMMIT, PENDING
  );
endinterface

// File: rtl/vshadow_ctrl.sv
// Double-buffered vertical compare registers committed at frame wrap, plus a deferred vertical-counter preload.
// NEXTV -> new ACT_* in 2 cycles; VLDL fires combinationally on the HD1 cycle; no backpressure, strobes always accepted.
module vshadow_ctrl (
  input logic           CLK,
  input logic           RESETL_0,
  vshadow_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // index 0 = start, 1 = end, 2 = int
  localparam logic [2:0][8:0] RST_VAL = {9'h0FF, 9'h100, 9'h020};

  logic [1:0]      state_q, state_d;
  logic [2:0][8:0] stg_q, stg_d;
  logic [2:0][8:0] act_q, act_d;
  logic [2:0]      arm_q, arm_d;
  logic [2:0]      wr_lo, wr_hi;
  logic [8:0]      pre_q, pre_d;
  logic [8:0]      vldd_q, vldd_d;
  logic            pend_q, pend_d;
  logic            in_commit, go, fire;

  assign wr_lo     = {bus.INTL, bus.ENDL, bus.STARTL};
  assign wr_hi     = {bus.INTH, bus.ENDH, bus.STARTH};
  assign in_commit = (state_q == ST_COMMIT);
  assign go        = bus.NEXTV | bus.DIAG;
  // Gated by reset so a reset cycle never emits a load strobe.
  assign fire      = RESETL_0 & pend_q & (bus.HD1 | bus.DIAG);

  always_comb begin
    stg_d = stg_q;
    act_d = act_q;
    arm_d = arm_q;
    for (int i = 0; i < 3; i++) begin
      if (in_commit && arm_q[i]) begin
        act_d[i] = stg_q[i];
        arm_d[i] = 1'b0;
      end
      if (wr_lo[i]) stg_d[i][7:0] = bus.WD;
      // A high write in the commit cycle re-arms for the following frame.
      if (wr_hi[i]) begin
        stg_d[i][8] = bus.WD[0];
        arm_d[i]    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // Arming coincident with the wrap commits at that same wrap.
        if (|arm_d) state_d = go ? ST_COMMIT : ST_ARMED;
      end
      ST_ARMED: begin
        if (go) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = (|arm_d) ? ST_ARMED : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pre_d  = pre_q;
    vldd_d = vldd_q;
    pend_d = pend_q;
    if (fire) begin
      vldd_d = pre_q;
      pend_d = 1'b0;
    end
    if (bus.VCNTH) pre_d[8] = bus.WD[0];
    if (bus.VCNTL) begin
      pre_d[7:0] = bus.WD;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETL_0) begin
      state_q <= ST_IDLE;
      stg_q   <= RST_VAL;
      act_q   <= RST_VAL;
      arm_q   <= 3'b000;
      pre_q   <= 9'h000;
      vldd_q  <= 9'h000;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
      act_q   <= act_d;
      arm_q   <= arm_d;
      pre_q   <= pre_d;
      vldd_q  <= vldd_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.ACT_START = act_q[0];
  assign bus.ACT_END   = act_q[1];
  assign bus.ACT_INT   = act_q[2];
  assign bus.VLDL      = ~fire;
  assign bus.VLDD      = fire ? pre_q : vldd_q;
  assign bus.COMMIT    = in_commit & RESETL_0;
  assign bus.PENDING   = |arm_q;

endmodule

// File: doc/vshadow_ctrl.md
VSHADOW_CTRL -- requirements
Module: vshadow_ctrl

Interface
REQ-001 CLK  in  1  system clock; all state changes on rising edge.
REQ-002 RESETL_0  in  1  reset, synchronous, active-low.
REQ-003 WD  in  8  CPU write data; low-byte writes use WD[7:0], high-byte writes use WD[0] as bit 8.
REQ-004 STARTL, STARTH, ENDL, ENDH, INTL, INTH  in  1 each  single-cycle write strobes, active high, for the low and high parts of the three vertical compare registers.
REQ-005 VCNTL, VCNTH  in  1 each  write strobes for a vertical-counter preload, low byte and bit 8.
REQ-006 NEXTV  in  1  one-cycle frame-wrap pulse from the vertical counter.
REQ-007 HD1  in  1  horizontal-count-equals-one pulse; the only safe instant to load the vertical counter.
REQ-008 DIAG  in  1  test mode; bypasses frame and line deferral.
REQ-009 ACT_START, ACT_END, ACT_INT  out  9 each  active compare values used by the vertical timebase.
REQ-010 VLDL  out  1  active-low one-cycle load strobe to the vertical counter.
REQ-011 VLDD  out  9  preload value presented with VLDL.
REQ-012 COMMIT  out  1  one-cycle pulse on the cycle the active registers update.
REQ-013 PENDING  out  1  high while any compare register is armed for commit.

Function
REQ-014 The block SHALL hold three 9-bit staging registers (start, end, int); an L strobe SHALL write bits 7:0 and an H strobe SHALL write bit 8.
REQ-015 An H strobe SHALL set that register's armed flag; an L strobe alone SHALL update staging without arming.
REQ-016 The FSM SHALL have states IDLE, ARMED and COMMIT.
REQ-017 FSM transitions: IDLE->ARMED when any armed flag is set; ARMED->COMMIT on NEXTV (or on any cycle while DIAG=1); COMMIT->IDLE when no flag is armed, otherwise COMMIT->ARMED.
REQ-018 In COMMIT, every armed register SHALL copy staging to active, and its flag SHALL clear.
REQ-019 COMMIT SHALL be high for exactly the COMMIT-state cycle; active outputs SHALL change on the edge that enters COMMIT+1, giving latency NEXTV->new ACT_* = 2 cycles.
REQ-020 Unarmed registers SHALL keep their active value through COMMIT, even when their staging differs.
REQ-021 An H strobe coincident with NEXTV SHALL arm its register, and the register SHALL commit at that NEXTV; the staging written that cycle is the value committed.
REQ-022 An H strobe arriving while in COMMIT SHALL re-arm its register, and the register SHALL commit at the next NEXTV.
REQ-023 Simultaneous L and H strobes to the same register SHALL both take effect.
REQ-024 PENDING SHALL equal the OR of the armed flags.
REQ-025 A VCNTH write SHALL store bit 8, and a VCNTL write SHALL store bits 7:0 and set load-pending.
REQ-026 A later VCNTL before the load completes SHALL overwrite the pending value; only one load SHALL occur.
REQ-027 While load-pending, on the first cycle with HD1=1 (or any cycle when DIAG=1) the block SHALL drive VLDL=0 for one cycle with VLDD=preload, then clear load-pending.
REQ-028 A VCNTL strobe coincident with HD1 SHALL be deferred to the next HD1.
REQ-029 VLDD SHALL hold its last value when VLDL=1.
REQ-030 The load path and the commit path SHALL be independent; both may fire in the same cycle.

Reset
REQ-031 With RESETL_0=0 at an edge, the block SHALL set: FSM=IDLE, all flags clear, load-pending clear, ACT_START=staging start=9'h020, ACT_END=staging end=9'h100, ACT_INT=staging int=9'h0FF, VLDD=0, VLDL=1, COMMIT=0, PENDING=0.
REQ-032 Reset mid-operation SHALL discard armed commits and pending loads, with no COMMIT or VLDL pulse issued.
REQ-033 Strobes SHALL be ignored during any cycle with RESETL_0=0.

Verification
REQ-034 The bench SHALL cover: STARTL WD=8'h34, then STARTH WD=8'h01, then NEXTV -> PENDING=1 until COMMIT, COMMIT pulses, ACT_START=9'h134 two cycles after NEXTV, and ACT_END and ACT_INT are unchanged.
REQ-035 The bench SHALL cover: ENDL WD=8'h50 only, then NEXTV -> no COMMIT, and ACT_END stays 9'h100.
REQ-036 The bench SHALL cover: INTH WD=0 in the same cycle as NEXTV -> commit occurs, and ACT_INT=9'h0FF (staging low byte unchanged).
REQ-037 The bench SHALL cover: VCNTH WD=1, VCNTL WD=8'h05, then VCNTL WD=8'h07, then HD1 -> a single VLDL=0 cycle with VLDD=9'h107.
REQ-038 The bench SHALL cover: DIAG=1 with STARTH written and no NEXTV -> COMMIT within 2 cycles.
REQ-039 The bench SHALL cover: arming INTH, then RESETL_0=0 for 1 cycle, then NEXTV -> no COMMIT, ACT_INT=9'h0FF, and PENDING=0.
